// File: rtl/mix_field_unit.sv
// mix_field_unit
//
// Partial-field unit for the MIX word datapath. From one set of operands it
// produces both:
//   - the load result: bytes L..R of mem_word, right-justified, with the sign
//     taken from mem_word only when L = 0 (otherwise +);
//   - the store result: mem_word with bytes L..R replaced by the rightmost
//     bytes of reg_word, sign replaced from reg_word only when L = 0.
// The field spec is F = 8L+R. It is valid only when L <= R <= NBYTES.
// An invalid field flags field_err, gives load = +0 and leaves mem_word
// unchanged on the store side.
//
// Word layout: bit W-1 is the sign (1 = negative). Byte 1 is the most
// significant magnitude byte and byte NBYTES is the least significant.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every output
//   valid_in   operands valid this cycle
//   fspec      field spec, L = fspec[5:3], R = fspec[2:0]
//   mem_word   memory word (load source / store destination)
//   reg_word   register value being stored
//   load_out   registered load result
//   store_out  registered store result
//   valid_out  registered valid_in
//   field_err  registered "fspec invalid" flag
//
// Handshake: valid_in is sampled at every rising edge and there is no ready
// signal, so the unit accepts one operand set per cycle. An operand set
// accepted at an edge shows up on the outputs right after that same edge,
// with valid_out = 1. When valid_in = 0 the data outputs and field_err hold
// their values and only valid_out drops.
module mix_field_unit #(
  parameter int BYTE_W = 6,
  parameter int NBYTES = 5,
  localparam int W = 1 + NBYTES * BYTE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [5:0]   fspec,
  input  logic [W-1:0] mem_word,
  input  logic [W-1:0] reg_word,
  output logic [W-1:0] load_out,
  output logic [W-1:0] store_out,
  output logic         valid_out,
  output logic         field_err
);

  int             l_idx;
  int             r_idx;
  int             lb;
  logic           field_ok;
  logic [W-1:0]   load_next;
  logic [W-1:0]   store_next;

  // Bit offset of the low bit of magnitude byte i (1 = most significant).
  function automatic int byte_lsb(input int i);
    return (NBYTES - i) * BYTE_W;
  endfunction

  always_comb begin
    l_idx      = int'(fspec[5:3]);
    r_idx      = int'(fspec[2:0]);
    // The first magnitude byte. L = 0 names the sign, so the magnitude
    // range starts at byte 1. When R = 0 the range lb..R is empty.
    lb         = (l_idx == 0) ? 1 : l_idx;
    field_ok   = (l_idx <= r_idx) && (r_idx <= NBYTES);
    load_next  = '0;
    store_next = mem_word;

    if (field_ok) begin
      if (l_idx == 0) begin
        load_next[W-1]  = mem_word[W-1];
        store_next[W-1] = reg_word[W-1];
      end

      for (int i = 1; i <= NBYTES; i++) begin
        // Load: output byte i comes from source byte i-(NBYTES-R), so that
        // byte R lands in byte NBYTES. It is kept only when the source byte
        // is inside lb..R.
        if ((i + r_idx - NBYTES >= lb) && (i + r_idx - NBYTES <= r_idx)) begin
          load_next[byte_lsb(i) +: BYTE_W] =
            mem_word[byte_lsb(i + r_idx - NBYTES) +: BYTE_W];
        end
        // Store: byte i inside lb..R takes reg byte i+(NBYTES-R), which
        // aligns reg byte NBYTES with byte R.
        if ((i >= lb) && (i <= r_idx)) begin
          store_next[byte_lsb(i) +: BYTE_W] =
            reg_word[byte_lsb(i + NBYTES - r_idx) +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_out  <= '0;
      store_out <= '0;
      valid_out <= 1'b0;
      field_err <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        load_out  <= load_next;
        store_out <= store_next;
        field_err <= ~field_ok;
      end
    end
  end

endmodule

// File: tb/tb_mix_field_unit.sv
module tb_mix_field_unit;

  localparam int W = 31;

  logic         clk;
  logic         reset;
  logic         valid_in;
  logic [5:0]   fspec;
  logic [W-1:0] mem_word;
  logic [W-1:0] reg_word;
  logic [W-1:0] load_out;
  logic [W-1:0] store_out;
  logic         valid_out;
  logic         field_err;

  int test_cnt = 0;
  int fail_cnt = 0;

  mix_field_unit dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .fspec     (fspec),
    .mem_word  (mem_word),
    .reg_word  (reg_word),
    .load_out  (load_out),
    .store_out (store_out),
    .valid_out (valid_out),
    .field_err (field_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic s, input logic [5:0] b1,
                                      input logic [5:0] b2, input logic [5:0] b3,
                                      input logic [5:0] b4, input logic [5:0] b5);
    return {s, b1, b2, b3, b4, b5};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    test_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operand set and sample the outputs at the next falling edge.
  task automatic drive(input logic v, input logic [5:0] f);
    valid_in = v;
    fspec    = f;
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  localparam int NV = 12;
  logic [5:0]   vf [NV];
  logic [W-1:0] vload [NV];
  logic [W-1:0] vstore [NV];
  logic         verr [NV];

  logic [W-1:0] m_word;
  logic [W-1:0] r_word;

  initial begin
    m_word = mk(1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
    r_word = mk(1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10);

    // 0:5
    vf[0] = 6'd5;  vload[0] = mk(1, 1, 2, 3, 4, 5);  vstore[0] = mk(0, 6, 7, 8, 9, 10);  verr[0] = 0;
    // 1:5
    vf[1] = 6'd13; vload[1] = mk(0, 1, 2, 3, 4, 5);  vstore[1] = mk(1, 6, 7, 8, 9, 10);  verr[1] = 0;
    // 3:3
    vf[2] = 6'd27; vload[2] = mk(0, 0, 0, 0, 0, 3);  vstore[2] = mk(1, 1, 2, 10, 4, 5);  verr[2] = 0;
    // 0:2
    vf[3] = 6'd2;  vload[3] = mk(1, 0, 0, 0, 1, 2);  vstore[3] = mk(0, 9, 10, 3, 4, 5);  verr[3] = 0;
    // 0:0, sign only
    vf[4] = 6'd0;  vload[4] = mk(1, 0, 0, 0, 0, 0);  vstore[4] = mk(0, 1, 2, 3, 4, 5);   verr[4] = 0;
    // 2:2
    vf[5] = 6'd18; vload[5] = mk(0, 0, 0, 0, 0, 2);  vstore[5] = mk(1, 1, 10, 3, 4, 5);  verr[5] = 0;
    // 1:4
    vf[6] = 6'd12; vload[6] = mk(0, 0, 1, 2, 3, 4);  vstore[6] = mk(1, 7, 8, 9, 10, 5);  verr[6] = 0;
    // 5:5
    vf[7] = 6'd45; vload[7] = mk(0, 0, 0, 0, 0, 5);  vstore[7] = mk(1, 1, 2, 3, 4, 10);  verr[7] = 0;
    // 4:2 invalid (L > R)
    vf[8] = 6'd34; vload[8] = '0;                    vstore[8] = m_word;                 verr[8] = 1;
    // 0:7 invalid (R > 5)
    vf[9] = 6'd7;  vload[9] = '0;                    vstore[9] = m_word;                 verr[9] = 1;
    // 0:6 invalid (R just past the end)
    vf[10] = 6'd6; vload[10] = '0;                   vstore[10] = m_word;                verr[10] = 1;
    // 0:1
    vf[11] = 6'd1; vload[11] = mk(1, 0, 0, 0, 0, 1); vstore[11] = mk(0, 10, 2, 3, 4, 5); verr[11] = 0;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    fspec    = '0;
    mem_word = mk(1'b1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5);
    reg_word = mk(1'b0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10);
    @(negedge clk);
    @(negedge clk);
    check("reset_load",  load_out, '0);
    check("reset_store", store_out, '0);
    check("reset_valid", {30'd0, valid_out}, '0);
    check("reset_err",   {30'd0, field_err}, '0);
    reset = 1'b0;

    // Directed vectors, each separated by an idle cycle.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vf[i]);
      check($sformatf("load_f%0d", vf[i]),  load_out,  vload[i]);
      check($sformatf("store_f%0d", vf[i]), store_out, vstore[i]);
      check($sformatf("err_f%0d", vf[i]),   {30'd0, field_err}, {30'd0, verr[i]});
      check($sformatf("valid_f%0d", vf[i]), {30'd0, valid_out}, 31'd1);
      drive(1'b0, 6'd0);
      check($sformatf("idle_valid_f%0d", vf[i]), {30'd0, valid_out}, '0);
    end

    // Streaming: F = 13, 27, 2 on consecutive cycles.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, vf[k]);
      check($sformatf("stream_load_%0d", k),  load_out,  vload[k]);
      check($sformatf("stream_store_%0d", k), store_out, vstore[k]);
      check($sformatf("stream_valid_%0d", k), {30'd0, valid_out}, 31'd1);
    end
    // Drop valid_in and change the operands: data outputs must hold.
    mem_word = '0;
    reg_word = '1;
    drive(1'b0, 6'd34);
    check("hold_valid", {30'd0, valid_out}, '0);
    check("hold_load",  load_out,  vload[3]);
    check("hold_store", store_out, vstore[3]);
    check("hold_err",   {30'd0, field_err}, '0);
    drive(1'b0, 6'd5);
    check("hold2_load", load_out, vload[3]);

    // An error flag also holds over idle cycles.
    mem_word = m_word;
    reg_word = r_word;
    drive(1'b1, 6'd7);
    check("err_set", {30'd0, field_err}, 31'd1);
    drive(1'b0, 6'd5);
    check("err_hold", {30'd0, field_err}, 31'd1);

    // Reset wins over valid_in in the same cycle.
    drive(1'b1, 6'd5);
    check("pre_rst_load", load_out, vload[0]);
    reset = 1'b1;
    drive(1'b1, 6'd7);
    check("rst_ov_load",  load_out, '0);
    check("rst_ov_store", store_out, '0);
    check("rst_ov_valid", {30'd0, valid_out}, '0);
    check("rst_ov_err",   {30'd0, field_err}, '0);
    reset = 1'b0;
    drive(1'b1, 6'd5);
    check("post_rst_load",  load_out,  vload[0]);
    check("post_rst_store", store_out, vstore[0]);
    check("post_rst_valid", {30'd0, valid_out}, 31'd1);
    check("post_rst_err",   {30'd0, field_err}, '0);
    drive(1'b0, 6'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mix_field_unit.md
Name: mix_field_unit

Overview:
- Partial-field unit for the MIX word datapath, covering load-side field extraction and store-side field merge in one block.
- Decodes the MIX field specification F = 8L+R and extracts bytes L..R from a memory word, right-justified, for LDx.
- Also merges the rightmost bytes of a register value into bytes L..R of a memory word for STx.
- Sits between the memory data register and the register file / store path; both results are registered with one-cycle latency.

Parameters:
- BYTE_W, 6, bits per MIX byte.
- NBYTES, 5, bytes per word magnitude; word width W = 1 + NBYTES*BYTE_W = 31.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  operands valid; sampled on the rising clk edge.
- fspec  input  6  field spec F = 8L+R; L = fspec[5:3], R = fspec[2:0].
- mem_word  input  31  memory word: bit30 is the sign (1 = negative), then byte1 = [29:24] (most significant) through byte5 = [5:0].
- reg_word  input  31  register value to store, same format.
- load_out  output  31  extracted field (load result).
- store_out  output  31  mem_word with field L..R replaced (store result).
- valid_out  output  1  results valid.
- field_err  output  1  fspec invalid.

Behaviour:
- Reset: while reset is high at a clk edge, load_out = 0, store_out = 0, valid_out = 0 and field_err = 0. Reset overrides valid_in in the same cycle.
- Latency: a valid_in accepted at edge N produces outputs at edge N; they are visible the cycle after operands are presented. valid_out = registered valid_in.
- Outputs hold their values when valid_in = 0; only valid_out drops to 0.
- Back-to-back valid_in gives one result per cycle. There is no backpressure.
- Field validity: valid iff L <= R and R <= 5. Otherwise field_err = 1, load_out = +0 (all zeros) and store_out = mem_word unchanged.
- Sign rule: the sign takes part only if L = 0. Define Lb = max(L,1) as the first magnitude byte. The magnitude part is empty when R = 0.
- Load, sign:
  - L = 0: load_out[30] = mem_word[30].
  - L > 0: load_out[30] = 0 (positive).
- Load, magnitude:
  - Bytes Lb..R of mem_word are moved so that byte R lands in byte5.
  - The higher bytes are zero-filled. Equivalently, magnitude = (mem_word[29:0] >> 6*(5-R)) masked to (R-Lb+1) bytes.
  - Field (0:0) yields sign only, magnitude 0.
- Store, sign:
  - L = 0: store_out[30] = reg_word[30].
  - L > 0: store_out[30] = mem_word[30].
- Store, magnitude:
  - Bytes Lb..R of store_out come from the rightmost (R-Lb+1) bytes of reg_word; reg byte5 goes to byte R, and so on.
  - All other bytes are taken from mem_word.
  - Field (0:0) replaces the sign only.
- Both results are computed every accepted cycle regardless of the operation; the consumer selects which one to use.
- Field extraction is purely byte-granular. No arithmetic, no carries.

Test Plan:
- Load with M = −[1,2,3,4,5] (sign 1, bytes 1..5); a result [a,b,c,d,e] lists bytes 1..5:
  - F = 5 (0:5) -> load_out = −[1,2,3,4,5].
  - F = 13 (1:5) -> +[1,2,3,4,5].
  - F = 27 (3:3) -> +[0,0,0,0,3].
  - F = 2 (0:2) -> −[0,0,0,1,2].
  - F = 0 -> −[0,0,0,0,0].
  - field_err = 0 and valid_out = 1 one cycle later for each.
- Store with M = −[1,2,3,4,5] and reg = +[6,7,8,9,10]:
  - F = 5 -> store_out = +[6,7,8,9,10].
  - F = 13 -> −[6,7,8,9,10].
  - F = 18 (2:2) -> −[1,10,3,4,5].
  - F = 0 -> +[1,2,3,4,5].
  - F = 12 (1:4) -> −[7,8,9,10,5].
- Invalid field: F = 34 (4:2) and F = 7 (0:7) -> field_err = 1, load_out = 0, store_out = M.
- Streaming: present F = 13, 27, 2 on consecutive cycles -> matching results on the three following cycles with valid_out held at 1. Then drop valid_in -> valid_out = 0, data outputs hold.
- Reset: assert reset together with valid_in = 1 -> the next cycle shows all outputs 0. Deassert reset and present F = 5 -> a normal result one cycle later.
